reg_file_dump_reader: RTL and testbench

//  Sequential reader for the 32-entry register file. On request it walks a

---
 rtl/reg_file_dump_reader.sv | 153 +++++++++++++++
 tb/tb_reg_file_dump_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump_reader.sv
// Sequential register-file dump reader: walks [first, last] through a private
// read port and streams each captured word out on a valid/ready port.
module reg_file_dump_reader #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] first_reg_i,
    input  logic [ADDR_W-1:0] last_reg_i,
    output logic [ADDR_W-1:0] read_register_o,
    input  logic [N-1:0]      read_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [N-1:0]      dump_data_o,
    output logic [ADDR_W-1:0] dump_index_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a word transfers on any rising edge where dump_valid_o and
    // dump_ready_i are both high; while valid is high and ready is low, the
    // data/index/last outputs hold. Valid falls only on a transfer or an abort.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [N-1:0]      data_q, data_d;
    logic              valid_q, valid_d;
    logic              dlast_q, dlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              handshake;
    logic              at_last;

    assign handshake = valid_q & dump_ready_i;
    assign at_last   = (cur_q == last_q);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        dlast_d = dlast_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (first_reg_i <= last_reg_i) begin
                        cur_d   = first_reg_i;
                        last_d  = last_reg_i;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    dlast_d = 1'b0;
                end else begin
                    // The word is a snapshot taken here; later writes cannot touch it.
                    data_d  = read_data_i;
                    index_d = cur_q;
                    dlast_d = at_last;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Abort wins over a transfer offered in the same cycle.
                if (abort_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    dlast_d = 1'b0;
                end else if (handshake) begin
                    valid_d = 1'b0;
                    if (at_last) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                dlast_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dlast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dlast_q <= dlast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign read_register_o = (state_q == S_LOAD) ? cur_q : '0;
    assign dump_valid_o    = valid_q;
    assign dump_data_o     = data_q;
    assign dump_index_o    = index_q;
    assign dump_last_o     = dlast_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Bench for reg_file_dump_reader: register-file model, dump-level reference
// model with expected-word queue, and directed scenarios with literal checks.
module tb_reg_file_dump_reader;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          dump_ready_i = 1'b0;
  logic [AW-1:0] first_reg_i = '0;
  logic [AW-1:0] last_reg_i = '0;
  logic [AW-1:0] read_register_o;
  logic [AW-1:0] dump_index_o;
  logic [N-1:0]  read_data_i;
  logic [N-1:0]  dump_data_o;
  logic          dump_valid_o, dump_last_o, busy_o, done_o, error_o;
  logic [1:0]    dbg_state_o;

  logic [N-1:0]  regs [32];
  int            errors = 0;
  int            checks = 0;

  reg_file_dump_reader #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .first_reg_i(first_reg_i), .last_reg_i(last_reg_i),
    .read_register_o(read_register_o), .read_data_i(read_data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_index_o(dump_index_o),
    .dump_last_o(dump_last_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset / register file
  always #5 clk = ~clk;
  assign read_data_i = (read_register_o == '0) ? '0 : regs[read_register_o];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected words are {last, index, data}
  logic [37:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic        prev_hold = 1'b0;
  logic [N-1:0]  prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;
  logic [N-1:0]  got_data [32];
  logic [AW-1:0] got_idx = '0;
  logic          got_last = 1'b0;
  int words_seen = 0, done_seen = 0, err_seen = 0;

  always @(negedge clk) begin
    logic [37:0] e;
    if (!reset) begin
      check("reset_quiet", {dump_valid_o, busy_o, done_o, error_o, dump_last_o,
                            dump_index_o, dump_data_o, read_register_o}, '0);
      exp_q.delete();
      m_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; prev_hold = 1'b0;
    end else begin
      check("busy", busy_o, m_busy);
      check("done", done_o, exp_done);
      check("error", error_o, exp_err);
      if (done_o) done_seen++;
      if (error_o) err_seen++;
      if (!m_busy) check("valid_idle", dump_valid_o, 1'b0);
      if (prev_hold) begin
        check("hold_valid", dump_valid_o, 1'b1);
        check("hold_data", dump_data_o, prev_data);
        check("hold_idx", dump_index_o, prev_idx);
        check("hold_last", dump_last_o, prev_last);
      end
      exp_done = 1'b0;
      exp_err = 1'b0;
      prev_hold = m_busy && dump_valid_o && !dump_ready_i && !abort_i;
      prev_data = dump_data_o;
      prev_idx = dump_index_o;
      prev_last = dump_last_o;
      if (!m_busy) begin
        if (start_i) begin
          if (first_reg_i <= last_reg_i) begin
            m_busy = 1'b1;
            for (int i = int'(first_reg_i); i <= int'(last_reg_i); i++)
              exp_q.push_back({(i == int'(last_reg_i)), 5'(i), (i == 0) ? 32'h0 : regs[i]});
          end else begin
            exp_err = 1'b1;
          end
        end
      end else if (abort_i) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (dump_valid_o && dump_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", dump_index_o, 6'h3F);
        end else begin
          e = exp_q.pop_front();
          check("word_idx", dump_index_o, e[36:32]);
          check("word_data", dump_data_o, e[31:0]);
          check("word_last", dump_last_o, e[37]);
          words_seen++;
          got_data[dump_index_o] = dump_data_o;
          got_idx = dump_index_o;
          got_last = dump_last_o;
          if (e[37]) begin
            m_busy = 1'b0;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_reg_i = f;
    last_reg_i = l;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy_o, 1'b0);
  endtask

  task automatic wait_word(input logic [AW-1:0] idx, input int budget);
    int n = 0;
    while (!(dump_valid_o && dump_index_o == idx) && n < budget) begin
      tick();
      n++;
    end
    check("word_timeout", {dump_valid_o, dump_index_o}, {1'b1, idx});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, e0, nb;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
    tick(3);
    check("rst_valid", dump_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_data", dump_data_o, 32'h0);
    reset = 1'b1;
    tick(2);

    // full walk 0..31 with ready held high
    dump_ready_i = 1'b1;
    w0 = words_seen; d0 = done_seen;
    do_start(5'd0, 5'd31);
    wait_idle(200);
    tick(2);
    check("t1_words", words_seen - w0, 32);
    check("t1_done", done_seen - d0, 1);
    check("t1_idx0_data", got_data[0], 32'h0);
    check("t1_idx31_data", got_data[31], 32'h1000_001F);
    check("t1_final", {got_last, got_idx}, {1'b1, 5'd31});

    // back-pressure on idx5
    w0 = words_seen; d0 = done_seen;
    do_start(5'd4, 5'd6);
    wait_word(5'd5, 20);
    dump_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall", {dump_valid_o, dump_index_o, dump_data_o}, {1'b1, 5'd5, 32'h1000_0005});
    end
    dump_ready_i = 1'b1;
    wait_idle(40);
    tick(2);
    check("t2_words", words_seen - w0, 3);
    check("t2_done", done_seen - d0, 1);
    check("t2_final", {got_last, got_idx, got_data[6]}, {1'b1, 5'd6, 32'h1000_0006});

    // single-word dump
    w0 = words_seen; d0 = done_seen;
    do_start(5'd9, 5'd9);
    check("t3_rd_addr", read_register_o, 5'd9);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_o) nb++;
      tick();
    end
    check("t3_busy_cycles", nb, 2);
    check("t3_words", words_seen - w0, 1);
    check("t3_done", done_seen - d0, 1);
    check("t3_final", {got_last, got_idx, got_data[9]}, {1'b1, 5'd9, 32'h1000_0009});

    // first > last
    e0 = err_seen;
    do_start(5'd10, 5'd3);
    check("t4_err_pulse", {error_o, busy_o, dump_valid_o}, 3'b100);
    tick();
    check("t4_err_clear", error_o, 1'b0);
    tick(2);
    check("t4_err_count", err_seen - e0, 1);

    // snapshot, start-while-busy, abort
    w0 = words_seen; d0 = done_seen;
    do_start(5'd6, 5'd9);
    wait_word(5'd7, 20);
    dump_ready_i = 1'b0;
    regs[7] = 32'hDEAD_BEEF;
    first_reg_i = 5'd0; last_reg_i = 5'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(2);
    check("t5_snapshot", {dump_index_o, dump_data_o}, {5'd7, 32'h1000_0007});
    dump_ready_i = 1'b1;
    wait_word(5'd8, 20);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_abort", {dump_valid_o, busy_o}, 2'b00);
    tick(3);
    check("t5_no_done", done_seen - d0, 0);
    check("t5_words", words_seen - w0, 2);
    regs[7] = 32'h1000_0007;

    // async reset while idx12 is held
    do_start(5'd10, 5'd14);
    wait_word(5'd12, 20);
    dump_ready_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_rst", {dump_valid_o, busy_o, done_o, dump_last_o, dump_index_o, dump_data_o}, '0);
    tick(2);
    reset = 1'b1;
    tick();
    dump_ready_i = 1'b1;
    w0 = words_seen; d0 = done_seen;
    do_start(5'd2, 5'd3);
    wait_idle(20);
    tick(2);
    check("t6_words", words_seen - w0, 2);
    check("t6_done", done_seen - d0, 1);
    check("t6_final", {got_last, got_idx, got_data[3]}, {1'b1, 5'd3, 32'h1000_0003});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
